// File: rtl/seq_delay_checker.sv
// Hardware checker for "a, then b exactly DELAY cycles later", evaluated every clock
// with overlapping attempts; reports stamped verdicts and saturating pass/fail totals.
module seq_delay_checker #(
    parameter int DELAY = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             a,
    input  logic             b,
    output logic             start_fail,
    output logic             end_pass,
    output logic             end_fail,
    output logic [CNT_W-1:0] end_start_stamp,
    output logic [CNT_W-1:0] cycle,
    output logic [DELAY-1:0] inflight,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    // edge_cnt is the index of the edge about to happen; cycle shows the one just taken
    logic [CNT_W-1:0]            edge_cnt;
    logic [DELAY-1:0]            pend_valid;
    logic [DELAY-1:0][CNT_W-1:0] pend_stamp;

    logic [DELAY:0]              valid_shift;
    logic [DELAY:0][CNT_W-1:0]   stamp_shift;
    logic                        mature;
    logic                        new_start_fail;
    logic                        new_end_pass;
    logic                        new_end_fail;
    logic [CNT_W:0]              pass_sum;
    logic [CNT_W:0]              fail_sum;

    // Extra top stage keeps the shift expression valid when DELAY is 1
    always_comb begin
        valid_shift    = {pend_valid, en & a};
        stamp_shift    = {pend_stamp, edge_cnt};
        mature         = pend_valid[DELAY-1];
        new_start_fail = en & ~a;
        new_end_pass   = mature & b;
        new_end_fail   = mature & ~b;
        pass_sum       = {1'b0, pass_cnt} + {{CNT_W{1'b0}}, new_end_pass};
        fail_sum       = {1'b0, fail_cnt}
                       + {{(CNT_W-1){1'b0}}, new_start_fail & new_end_fail,
                          new_start_fail ^ new_end_fail};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt        <= '0;
            cycle           <= '0;
            pend_valid      <= '0;
            pend_stamp      <= '0;
            start_fail      <= 1'b0;
            end_pass        <= 1'b0;
            end_fail        <= 1'b0;
            end_start_stamp <= '0;
            pass_cnt        <= '0;
            fail_cnt        <= '0;
        end else begin
            edge_cnt   <= edge_cnt + CNT_W'(1);
            cycle      <= edge_cnt;
            pend_valid <= valid_shift[DELAY-1:0];
            pend_stamp <= stamp_shift[DELAY-1:0];
            start_fail <= new_start_fail;
            end_pass   <= new_end_pass;
            end_fail   <= new_end_fail;
            if (mature) begin
                end_start_stamp <= pend_stamp[DELAY-1];
            end
            // Carry-out of the widened sum means the total would pass all-ones
            pass_cnt <= pass_sum[CNT_W] ? '1 : pass_sum[CNT_W-1:0];
            fail_cnt <= fail_sum[CNT_W] ? '1 : fail_sum[CNT_W-1:0];
        end
    end

    assign inflight = pend_valid;

endmodule

// File: tb/tb_seq_delay_checker.sv
// Bench for seq_delay_checker: DELAY=2/CNT_W=16, DELAY=2/CNT_W=4 and DELAY=1 instances,
// table vectors plus loops, all checked through an expected-result queue.
module tb_seq_delay_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // dut0: DELAY=2, CNT_W=16
    logic rst0 = 1'b1, en0 = 1'b0, a0 = 1'b0, b0 = 1'b0;
    logic sf0, ep0, ef0;
    logic [15:0] st0, cyc0, pc0, fc0;
    logic [1:0]  inf0;
    // dut1: DELAY=2, CNT_W=4
    logic rst1 = 1'b1, en1 = 1'b0, a1 = 1'b0, b1 = 1'b0;
    logic sf1, ep1, ef1;
    logic [3:0]  st1, cyc1, pc1, fc1;
    logic [1:0]  inf1;
    // dut2: DELAY=1, CNT_W=16
    logic rst2 = 1'b1, en2 = 1'b0, a2 = 1'b0, b2 = 1'b0;
    logic sf2, ep2, ef2;
    logic [15:0] st2, cyc2, pc2, fc2;
    logic [0:0]  inf2;

    seq_delay_checker #(.DELAY(2), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst0), .en(en0), .a(a0), .b(b0),
        .start_fail(sf0), .end_pass(ep0), .end_fail(ef0), .end_start_stamp(st0),
        .cycle(cyc0), .inflight(inf0), .pass_cnt(pc0), .fail_cnt(fc0));

    seq_delay_checker #(.DELAY(2), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst1), .en(en1), .a(a1), .b(b1),
        .start_fail(sf1), .end_pass(ep1), .end_fail(ef1), .end_start_stamp(st1),
        .cycle(cyc1), .inflight(inf1), .pass_cnt(pc1), .fail_cnt(fc1));

    seq_delay_checker #(.DELAY(1), .CNT_W(16)) dut2 (
        .clk(clk), .rst(rst2), .en(en2), .a(a2), .b(b2),
        .start_fail(sf2), .end_pass(ep2), .end_fail(ef2), .end_start_stamp(st2),
        .cycle(cyc2), .inflight(inf2), .pass_cnt(pc2), .fail_cnt(fc2));

    typedef struct {
        logic        sf, ep, ef;
        logic [15:0] stamp, cyc, pc, fc;
        logic [1:0]  infl;
    } exp_t;

    typedef struct {
        bit          rst_before;
        logic        en, a, b;
        logic        sf, ep, ef;
        logic [15:0] stamp;
        logic [1:0]  infl;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[16];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    function automatic exp_t observe(input int which);
        exp_t o;
        o = '{1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 2'd0};
        case (which)
            0: o = '{sf0, ep0, ef0, st0, cyc0, pc0, fc0, inf0};
            1: o = '{sf1, ep1, ef1, {12'd0, st1}, {12'd0, cyc1}, {12'd0, pc1}, {12'd0, fc1}, inf1};
            default: o = '{sf2, ep2, ef2, st2, cyc2, pc2, fc2, {1'b0, inf2}};
        endcase
        return o;
    endfunction

    task automatic check_pop(input int which, input string tag);
        exp_t e, o;
        if (sb.size() == 0) begin
            cmp({tag, "_queue_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        o = observe(which);
        $display("dut%0d %s cyc=%0d sf=%0b ep=%0b ef=%0b stamp=%0d infl=%b pc=%0d fc=%0d",
                 which, tag, o.cyc, o.sf, o.ep, o.ef, o.stamp, o.infl, o.pc, o.fc);
        cmp({tag, "_start_fail"}, {31'd0, o.sf}, {31'd0, e.sf});
        cmp({tag, "_end_pass"},   {31'd0, o.ep}, {31'd0, e.ep});
        cmp({tag, "_end_fail"},   {31'd0, o.ef}, {31'd0, e.ef});
        if (e.ep || e.ef) cmp({tag, "_stamp"}, {16'd0, o.stamp}, {16'd0, e.stamp});
        cmp({tag, "_cycle"},    {16'd0, o.cyc},  {16'd0, e.cyc});
        cmp({tag, "_inflight"}, {30'd0, o.infl}, {30'd0, e.infl});
        cmp({tag, "_pass_cnt"}, {16'd0, o.pc},   {16'd0, e.pc});
        cmp({tag, "_fail_cnt"}, {16'd0, o.fc},   {16'd0, e.fc});
    endtask

    task automatic drive(input int which, input logic en_v, input logic a_v, input logic b_v);
        case (which)
            0: begin en0 = en_v; a0 = a_v; b0 = b_v; end
            1: begin en1 = en_v; a1 = a_v; b1 = b_v; end
            default: begin en2 = en_v; a2 = a_v; b2 = b_v; end
        endcase
    endtask

    task automatic step(input int which, input logic en_v, input logic a_v, input logic b_v,
                        input string tag);
        drive(which, en_v, a_v, b_v);
        @(posedge clk);
        @(negedge clk);
        check_pop(which, tag);
    endtask

    // Asserts reset mid-cycle and checks that outputs clear without any clock edge.
    // Returns just before the next rising edge so that edge becomes post-reset edge 0.
    task automatic pulse_reset(input int which);
        exp_t o;
        drive(which, 1'b0, 1'b0, 1'b0);
        #2;
        case (which)
            0: rst0 = 1'b1;
            1: rst1 = 1'b1;
            default: rst2 = 1'b1;
        endcase
        #1;
        o = observe(which);
        $display("dut%0d reset sf=%0b ep=%0b ef=%0b stamp=%0d cyc=%0d infl=%b pc=%0d fc=%0d",
                 which, o.sf, o.ep, o.ef, o.stamp, o.cyc, o.infl, o.pc, o.fc);
        cmp("rst_start_fail", {31'd0, o.sf}, 32'd0);
        cmp("rst_end_pass",   {31'd0, o.ep}, 32'd0);
        cmp("rst_end_fail",   {31'd0, o.ef}, 32'd0);
        cmp("rst_stamp",      {16'd0, o.stamp}, 32'd0);
        cmp("rst_cycle",      {16'd0, o.cyc}, 32'd0);
        cmp("rst_inflight",   {30'd0, o.infl}, 32'd0);
        cmp("rst_pass_cnt",   {16'd0, o.pc}, 32'd0);
        cmp("rst_fail_cnt",   {16'd0, o.fc}, 32'd0);
        #1;
        case (which)
            0: rst0 = 1'b0;
            1: rst1 = 1'b0;
            default: rst2 = 1'b0;
        endcase
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   edge_idx;
        int   pc_m;
        int   fc_m;
        logic bv;

        // Segment A: the reference ten-edge run. Segment B: reset while two attempts
        // are pending, then en dropped while attempts 1 and 2 are still in flight.
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 2'b00};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 2'b01};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 2'b11};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 2'b11};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd2, 2'b11};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd3, 2'b10};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd4, 2'b01};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 2'b11};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd6, 2'b11};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd7, 2'b11};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 2'b01};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 2'b11};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 2'b11};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1, 2'b10};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2, 2'b00};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 2'b00};

        @(negedge clk);
        edge_idx = 0;
        pc_m = 0;
        fc_m = 0;
        for (int i = 0; i < 16; i++) begin
            if (tbl[i].rst_before) begin
                @(negedge clk);
                pulse_reset(0);
                edge_idx = 0;
                pc_m = 0;
                fc_m = 0;
            end
            pc_m += int'(tbl[i].ep);
            fc_m += int'(tbl[i].sf) + int'(tbl[i].ef);
            e = '{tbl[i].sf, tbl[i].ep, tbl[i].ef, tbl[i].stamp, 16'(edge_idx),
                  16'(pc_m), 16'(fc_m), tbl[i].infl};
            sb.push_back(e);
            step(0, tbl[i].en, tbl[i].a, tbl[i].b, $sformatf("t%0d", i));
            edge_idx++;
        end

        // CNT_W=4: pass total saturates at 15, cycle and stamps wrap modulo 16
        @(negedge clk);
        pulse_reset(1);
        for (int k = 0; k < 40; k++) begin
            e.sf    = 1'b0;
            e.ep    = (k >= 2);
            e.ef    = 1'b0;
            e.stamp = 16'((k - 2) & 15);
            e.cyc   = 16'(k & 15);
            e.pc    = (k < 2) ? 16'd0 : ((k - 1 > 15) ? 16'd15 : 16'(k - 1));
            e.fc    = 16'd0;
            e.infl  = (k == 0) ? 2'b01 : 2'b11;
            sb.push_back(e);
            step(1, 1'b1, 1'b1, 1'b1, $sformatf("w%0d", k));
        end

        // DELAY=1: verdict at edge k+1 follows b sampled at edge k+1
        @(negedge clk);
        pulse_reset(2);
        pc_m = 0;
        fc_m = 0;
        for (int k = 0; k < 10; k++) begin
            bv = (k != 0) && (k % 2 == 1);
            e.sf    = 1'b0;
            e.ep    = (k >= 1) && bv;
            e.ef    = (k >= 1) && !bv;
            pc_m   += int'(e.ep);
            fc_m   += int'(e.ef);
            e.stamp = 16'(k - 1);
            e.cyc   = 16'(k);
            e.pc    = 16'(pc_m);
            e.fc    = 16'(fc_m);
            e.infl  = 2'b01;
            sb.push_back(e);
            step(2, 1'b1, 1'b1, bv, $sformatf("d%0d", k));
        end

        cmp("queue_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_delay_checker.md
# seq_delay_checker

Synthesizable hardware checker for the two-signal delay property "a, then b exactly DELAY cycles later". It is evaluated on every clock, with overlapping attempts, and matches the pass/fail semantics the team's `a ##N b` assertion benches expect. It sits directly downstream of the random a/b stimulus stage and consumes its `a`/`b` stream. It produces cycle-stamped pass/fail events and running totals, so FPGA and emulation runs give the same verdicts as simulation assertions.

## Interface
- `DELAY`, 2: cycles between the `a` sample and the `b` check; legal range 1..16.
- `CNT_W`, 16: width of the cycle stamp and the pass/fail totals.

- `clk`  in  1  sampling clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  when high, a new attempt starts at this edge.
- `a`  in  1  antecedent, sampled at the rising edge of `clk`.
- `b`  in  1  consequent, sampled at the rising edge of `clk`.
- `start_fail`  out  1  pulse: an attempt started with `a`=0 and fails in the same cycle.
- `end_pass`  out  1  pulse: a matured attempt saw `b`=1.
- `end_fail`  out  1  pulse: a matured attempt saw `b`=0.
- `end_start_stamp`  out  CNT_W  cycle stamp of the attempt reported by `end_pass`/`end_fail`.
- `cycle`  out  CNT_W  free-running sample-edge counter.
- `inflight`  out  DELAY  bit i is set when an attempt that started i+1 edges ago is pending.
- `pass_cnt`  out  CNT_W  saturating total of `end_pass` events.
- `fail_cnt`  out  CNT_W  saturating total of `start_fail` plus `end_fail` events.

## Operation
- At each rising edge k with `en`=1, an attempt starts:
  - `a`=0: `start_fail` is set in the cycle after edge k. The attempt is not queued.
  - `a`=1: the attempt enters the pending shift register with stamp `cycle`=k.
- Pending register: DELAY stages, each holding a valid bit and a stamp. It shifts every edge whatever the value of `en`.
- Maturity: an attempt queued at edge k is evaluated at edge k+DELAY against the `b` sampled at that edge.
  - `b`=1: `end_pass` is set.
  - `b`=0: `end_fail` is set.
  - In both cases `end_start_stamp` is loaded with k.
- `en`=0: no attempt starts and `start_fail` is not raised. Attempts already pending still mature and still report.
- Simultaneous events:
  - `start_fail` and `end_pass` or `end_fail` can be set in the same cycle. They are independent.
  - When both failure kinds occur at one edge, `fail_cnt` increments by 2.
  - `end_pass` and `end_fail` are mutually exclusive.
- Counters:
  - `pass_cnt` and `fail_cnt` saturate at 2^CNT_W−1.
  - `cycle` increments every edge and wraps modulo 2^CNT_W, so stamps wrap with it.
- `inflight` reflects the pending valid bits after the edge.

## Timing
- All outputs are registered. Events from edge k are visible from edge k until edge k+1, which is 1-cycle latency. Each pulse lasts exactly one cycle.
- Edge-to-verdict latency for an `a`=1 attempt is DELAY edges, and the verdict appears at the output one cycle later.
- `cycle` reads 0 in the cycle after the first edge following reset release. It reads 0 at that edge, then increments.
- Values at reset, and while `rst` is high: every output is 0 and every pending valid bit is cleared. Clearing is immediate, without waiting for `clk`.
- Reset during operation: pending attempts are discarded and never reported. Totals and `cycle` restart from 0.
- No handshake exists. Every edge is a sample, and there is no backpressure.

## Test plan
- DELAY=2, `en`=1. Drive samples (a,b) at edges 0..9: (0,1),(1,1),(1,1),(1,0),(1,1),(0,1),(1,0),(1,0),(1,0),(1,1). Required response:
  - `start_fail` at edges 0 and 5.
  - `end_fail` at edges 3, 6 and 8, with stamps 1, 4 and 6.
  - `end_pass` at edges 4, 5 and 9, with stamps 2, 3 and 7.
  - Final `pass_cnt`=3, `fail_cnt`=5, `inflight`=2'b11.
- Edge 5 of the first test must show `start_fail` and `end_pass` together. `fail_cnt` increments by exactly 1 and `pass_cnt` by exactly 1.
- Set `en`=0 at edge 3 of a run where a=1 at edges 1 and 2. Required:
  - No `start_fail`.
  - Attempts 1 and 2 still mature at edges 3 and 4.
  - `inflight` goes to 0 by edge 5.
- Pulse `rst` asynchronously, mid-cycle, while `inflight`=2'b11. Required:
  - All outputs go to 0 immediately.
  - No verdict is ever reported for the discarded attempts.
  - The first post-reset stamp is 0.
- CNT_W=4, with a=1 and b=1 every edge for 40 edges. Required:
  - `pass_cnt` holds at 15.
  - `cycle` and the stamps wrap 15 to 0 correctly, with the stamp equal to `cycle`−2 mod 16.
- DELAY=1, with a=1 and b alternating 1,0 from edge 1. Required: the verdict at edge k+1 matches b at edge k+1, one cycle after the `a` sample.
